module_alu_ctrl: RTL and testbench

// - Sequencer for module_ALU: accepts one command at a time over a valid/ready handshake and reads two operands from a local register bank.
// - Drives the ALU, captures result/flags and writes back to a destination register.
// - Sits between the board-level command source (switches/UART/FSM) and the ALU datapath.

---
 rtl/module_alu_ctrl_pkg.sv | 33 +++
 rtl/module_alu_ctrl_regbank.sv | 49 ++++
 rtl/module_alu_ctrl.sv | 169 ++++++++++++++++
 tb/tb_module_alu_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/module_alu_ctrl_pkg.sv
// Shared types for the ALU sequencer: opcode and FSM state encodings plus
// opcode classification helpers.
package pkg_alu_ctrl;

   typedef enum logic [3:0] {
      OP_AND = 4'h0,
      OP_OR  = 4'h1,
      OP_ADD = 4'h2,
      OP_INC = 4'h3,
      OP_DEC = 4'h4,
      OP_NOT = 4'h5,
      OP_SUB = 4'h6,
      OP_XOR = 4'h7,
      OP_SLL = 4'h8,
      OP_SRL = 4'h9
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_e;

   // Ops whose flag output is meaningful as a carry; the rest leave carry alone.
   function automatic logic is_carry_op(input logic [3:0] op);
      return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLL, OP_SRL};
   endfunction

   function automatic logic is_legal_op(input logic [3:0] op);
      return op <= OP_SRL;
   endfunction

endpackage

// File: rtl/module_alu_ctrl_regbank.sv
// NREGS x N register bank: one write port, three asynchronous read ports,
// all entries cleared by asynchronous reset.
module module_alu_regbank #(
   parameter int N     = 4,
   parameter int NREGS = 4,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [N-1:0]  wdata_i,
   input  logic [AW-1:0] ra_addr_i,
   input  logic [AW-1:0] rb_addr_i,
   input  logic [AW-1:0] rc_addr_i,
   output logic [N-1:0]  ra_data_o,
   output logic [N-1:0]  rb_data_o,
   output logic [N-1:0]  rc_data_o
);

   logic [N-1:0]     mem_reg [NREGS];
   logic [NREGS-1:0] wsel;

   genvar gi;
   generate
      for (gi = 0; gi < NREGS; gi++) begin : g_wsel
         assign wsel[gi] = we_i && (waddr_i == AW'(gi));
      end
   endgenerate

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NREGS; i++) begin
            mem_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (wsel[i]) begin
               mem_reg[i] <= wdata_i;
            end
         end
      end
   end

   assign ra_data_o = mem_reg[ra_addr_i];
   assign rb_data_o = mem_reg[rb_addr_i];
   assign rc_data_o = mem_reg[rc_addr_i];

endmodule

// File: rtl/module_alu_ctrl.sv
// Command sequencer for an external ALU: IDLE -> EXEC -> WB, register bank
// operands, stored carry/zero flags. Optional feature macro: CARRY_CHAIN_EN.
module module_alu_ctrl
   import pkg_alu_ctrl::*;
#(
   parameter int N     = 4,
   parameter int NREGS = 4,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          cmd_valid_i,
   output logic          cmd_ready_o,
   input  logic [3:0]    cmd_op_i,
   input  logic [AW-1:0] cmd_ra_i,
   input  logic [AW-1:0] cmd_rb_i,
   input  logic [AW-1:0] cmd_rd_i,
   input  logic          cmd_flagin_i,
   input  logic          ld_en_i,
   input  logic [AW-1:0] ld_addr_i,
   input  logic [N-1:0]  ld_data_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [N-1:0]  rd_data_o,
   output logic [N-1:0]  alu_a_o,
   output logic [N-1:0]  alu_b_o,
   output logic [3:0]    alu_cont_o,
   output logic          alu_flagin_o,
   input  logic [N-1:0]  alu_result_i,
   input  logic          alu_flagout_i,
   input  logic          alu_flagz_i,
   output logic [N-1:0]  result_o,
   output logic          carry_o,
   output logic          zero_o,
   output logic          done_o,
   output logic          err_o
);

   state_e        state_reg, state_next;
   logic [3:0]    op_reg;
   logic [AW-1:0] ra_reg, rb_reg, rd_reg;
   logic          flagin_reg;
   logic [N-1:0]  hold_result_reg;
   logic          hold_carry_reg, hold_zero_reg;
   logic [N-1:0]  result_reg;
   logic          carry_reg, zero_reg;

   logic          accept;
   logic          op_legal;
   logic          flagin_eff;
   logic          we;
   logic [AW-1:0] waddr;
   logic [N-1:0]  wdata;
   logic [N-1:0]  ra_data, rb_data;

   module_alu_regbank #(
      .N     (N),
      .NREGS (NREGS),
      .AW    (AW)
   ) u_regbank (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .we_i      (we),
      .waddr_i   (waddr),
      .wdata_i   (wdata),
      .ra_addr_i (ra_reg),
      .rb_addr_i (rb_reg),
      .rc_addr_i (rd_addr_i),
      .ra_data_o (ra_data),
      .rb_data_o (rb_data),
      .rc_data_o (rd_data_o)
   );

   assign op_legal = is_legal_op(op_reg);

`ifdef CARRY_CHAIN_EN
   // Multi-word add/subtract: chain the stored carry instead of the command bit.
   assign flagin_eff = (op_reg == OP_ADD || op_reg == OP_SUB) ? carry_reg : flagin_reg;
`else
   assign flagin_eff = flagin_reg;
`endif

   always_comb begin
      state_next   = state_reg;
      accept       = 1'b0;
      cmd_ready_o  = 1'b0;
      alu_a_o      = '0;
      alu_b_o      = '0;
      alu_cont_o   = '0;
      alu_flagin_o = 1'b0;
      done_o       = 1'b0;
      err_o        = 1'b0;
      we           = 1'b0;
      waddr        = '0;
      wdata        = '0;
      case (state_reg)
         IDLE: begin
            // A direct load wins the write port and blocks the handshake.
            cmd_ready_o = !ld_en_i;
            if (ld_en_i) begin
               we    = 1'b1;
               waddr = ld_addr_i;
               wdata = ld_data_i;
            end else if (cmd_valid_i) begin
               accept     = 1'b1;
               state_next = EXEC;
            end
         end
         EXEC: begin
            alu_a_o      = ra_data;
            alu_b_o      = rb_data;
            alu_cont_o   = op_reg;
            alu_flagin_o = flagin_eff;
            state_next   = WB;
         end
         WB: begin
            done_o     = 1'b1;
            err_o      = !op_legal;
            we         = op_legal;
            waddr      = rd_reg;
            wdata      = hold_result_reg;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg       <= IDLE;
         op_reg          <= '0;
         ra_reg          <= '0;
         rb_reg          <= '0;
         rd_reg          <= '0;
         flagin_reg      <= 1'b0;
         hold_result_reg <= '0;
         hold_carry_reg  <= 1'b0;
         hold_zero_reg   <= 1'b0;
         result_reg      <= '0;
         carry_reg       <= 1'b0;
         zero_reg        <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            op_reg     <= cmd_op_i;
            ra_reg     <= cmd_ra_i;
            rb_reg     <= cmd_rb_i;
            rd_reg     <= cmd_rd_i;
            flagin_reg <= cmd_flagin_i;
         end
         if (state_reg == EXEC) begin
            hold_result_reg <= alu_result_i;
            hold_carry_reg  <= alu_flagout_i;
            hold_zero_reg   <= alu_flagz_i;
         end
         if (state_reg == WB && op_legal) begin
            result_reg <= hold_result_reg;
            zero_reg   <= hold_zero_reg;
            if (is_carry_op(op_reg)) begin
               carry_reg <= hold_carry_reg;
            end
         end
      end
   end

   assign result_o = result_reg;
   assign carry_o  = carry_reg;
   assign zero_o   = zero_reg;

endmodule

// File: tb/tb_module_alu_ctrl.sv
// Self-checking bench for module_alu_ctrl: directed vector table, corner-case
// sequences and randomized commands against a behavioural model with an ALU stub.
module tb_module_alu_ctrl;

   localparam int N     = 4;
   localparam int NREGS = 4;
   localparam int AW    = 2;

   logic          clk;
   logic          rst_i;
   logic          cmd_valid_i;
   logic          cmd_ready_o;
   logic [3:0]    cmd_op_i;
   logic [AW-1:0] cmd_ra_i, cmd_rb_i, cmd_rd_i;
   logic          cmd_flagin_i;
   logic          ld_en_i;
   logic [AW-1:0] ld_addr_i;
   logic [N-1:0]  ld_data_i;
   logic [AW-1:0] rd_addr_i;
   logic [N-1:0]  rd_data_o;
   logic [N-1:0]  alu_a_o, alu_b_o;
   logic [3:0]    alu_cont_o;
   logic          alu_flagin_o;
   logic [N-1:0]  alu_result_i;
   logic          alu_flagout_i;
   logic          alu_flagz_i;
   logic [N-1:0]  result_o;
   logic          carry_o, zero_o, done_o, err_o;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model state
   logic [N-1:0] m_regs [NREGS];
   logic [N-1:0] m_result;
   logic         m_carry, m_zero;

   module_alu_ctrl #(.N(N), .NREGS(NREGS)) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .cmd_valid_i   (cmd_valid_i),
      .cmd_ready_o   (cmd_ready_o),
      .cmd_op_i      (cmd_op_i),
      .cmd_ra_i      (cmd_ra_i),
      .cmd_rb_i      (cmd_rb_i),
      .cmd_rd_i      (cmd_rd_i),
      .cmd_flagin_i  (cmd_flagin_i),
      .ld_en_i       (ld_en_i),
      .ld_addr_i     (ld_addr_i),
      .ld_data_i     (ld_data_i),
      .rd_addr_i     (rd_addr_i),
      .rd_data_o     (rd_data_o),
      .alu_a_o       (alu_a_o),
      .alu_b_o       (alu_b_o),
      .alu_cont_o    (alu_cont_o),
      .alu_flagin_o  (alu_flagin_o),
      .alu_result_i  (alu_result_i),
      .alu_flagout_i (alu_flagout_i),
      .alu_flagz_i   (alu_flagz_i),
      .result_o      (result_o),
      .carry_o       (carry_o),
      .zero_o        (zero_o),
      .done_o        (done_o),
      .err_o         (err_o)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // ALU stand-in: returns {flag, result}
   function automatic logic [N:0] alu_fn(input logic [3:0] op, input logic [N-1:0] a,
                                         input logic [N-1:0] b, input logic fin);
      logic [N-1:0] r;
      logic         f;
      logic [N:0]   w;
      r = '0;
      f = 1'b0;
      w = '0;
      case (op)
         4'h0: begin r = a & b; f = ^r; end
         4'h1: begin r = a | b; f = ^r; end
         4'h2: begin w = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, fin}; r = w[N-1:0]; f = w[N]; end
         4'h3: begin w = {1'b0, a} + (N+1)'(1); r = w[N-1:0]; f = w[N]; end
         4'h4: begin r = a - N'(1); f = (a == '0); end
         4'h5: begin r = ~a; f = ^r; end
         4'h6: begin w = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, fin}; r = w[N-1:0]; f = w[N]; end
         4'h7: begin r = a ^ b; f = ^r; end
         4'h8: begin r = {a[N-2:0], 1'b0}; f = a[N-1]; end
         4'h9: begin r = {1'b0, a[N-1:1]}; f = a[0]; end
         default: begin r = a ^ b ^ N'(5); f = 1'b1; end
      endcase
      return {f, r};
   endfunction

   always_comb {alu_flagout_i, alu_result_i} = alu_fn(alu_cont_o, alu_a_o, alu_b_o, alu_flagin_o);
   assign alu_flagz_i = (alu_result_i == '0);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
      m_result = '0;
      m_carry  = 1'b0;
      m_zero   = 1'b0;
   endtask

   // Reads every register through the observation port (4 time units)
   task automatic check_regs(input string tag);
      for (int i = 0; i < NREGS; i++) begin
         rd_addr_i = AW'(i);
         #1 check($sformatf("%s_reg%0d", tag, i), rd_data_o, m_regs[i]);
      end
   endtask

   task automatic do_load(input logic [AW-1:0] addr, input logic [N-1:0] data);
      @(negedge clk);
      ld_en_i   = 1'b1;
      ld_addr_i = addr;
      ld_data_i = data;
      #1 check("load_ready_low", cmd_ready_o, 1'b0);
      @(negedge clk);
      ld_en_i = 1'b0;
      m_regs[addr] = data;
      $display("load R%0d = %h", addr, data);
   endtask

   task automatic run_cmd(input logic [3:0] op, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                          input logic [AW-1:0] rd, input logic fin, input bit ld_in_exec,
                          input bit align, output logic obs_err);
      logic [N-1:0] a, b;
      logic         fe;
      logic [N:0]   y;
      logic         legal;
      a  = m_regs[ra];
      b  = m_regs[rb];
      fe = fin;
`ifdef CARRY_CHAIN_EN
      if (op == 4'h2 || op == 4'h6) fe = m_carry;
`endif
      y     = alu_fn(op, a, b, fe);
      legal = (op <= 4'h9);
      if (align) @(negedge clk);
      cmd_op_i     = op;
      cmd_ra_i     = ra;
      cmd_rb_i     = rb;
      cmd_rd_i     = rd;
      cmd_flagin_i = fin;
      cmd_valid_i  = 1'b1;
      #1 check("cmd_ready_idle", cmd_ready_o, 1'b1);
      @(negedge clk);
      // EXEC: scramble the command bus to show the command was latched
      cmd_valid_i  = 1'b0;
      cmd_op_i     = 4'($urandom);
      cmd_ra_i     = AW'($urandom);
      cmd_rb_i     = AW'($urandom);
      cmd_flagin_i = ~fin;
      if (ld_in_exec) begin
         ld_en_i   = 1'b1;
         ld_addr_i = ra;
         ld_data_i = ~a;
      end
      #1;
      check("exec_alu_cont", alu_cont_o, op);
      check("exec_alu_a", alu_a_o, a);
      check("exec_alu_b", alu_b_o, b);
      check("exec_alu_flagin", alu_flagin_o, fe);
      check("exec_done_low", done_o, 1'b0);
      check("exec_ready_low", cmd_ready_o, 1'b0);
      @(negedge clk);
      ld_en_i = 1'b0;
      #1;
      obs_err = err_o;
      check("wb_done", done_o, 1'b1);
      check("wb_err", err_o, !legal);
      check("wb_ready_low", cmd_ready_o, 1'b0);
      check("wb_alu_cont_idle", alu_cont_o, 4'h0);
      if (legal) begin
         m_regs[rd] = y[N-1:0];
         m_result   = y[N-1:0];
         m_zero     = (y[N-1:0] == '0);
         if (op inside {4'h0, 4'h1, 4'h2, 4'h6, 4'h8, 4'h9}) m_carry = y[N];
      end
      @(negedge clk);
      #1;
      check("idle_done_low", done_o, 1'b0);
      check("idle_err_low", err_o, 1'b0);
      check("idle_ready", cmd_ready_o, 1'b1);
      check("result", result_o, m_result);
      check("carry", carry_o, m_carry);
      check("zero", zero_o, m_zero);
      check_regs("post_cmd");
      $display("cmd op=%h ra=%0d rb=%0d rd=%0d fin=%0b -> result=%h carry=%0b zero=%0b err=%0b",
               op, ra, rb, rd, fin, result_o, carry_o, zero_o, obs_err);
   endtask

   typedef struct {
      bit            do_ld;
      logic [N-1:0]  l0, l1;
      logic [3:0]    op;
      logic [AW-1:0] ra, rb, rd;
      logic          fin;
      logic [N-1:0]  exp_res;
      logic          exp_c, exp_z, exp_err;
      logic [N-1:0]  exp_rdv;
   } vec_t;

   vec_t vecs [8];

   initial begin
      logic e;
      logic [3:0] rop;

      vecs[0] = '{1'b1, 4'h3, 4'h5, 4'h2, 2'd0, 2'd1, 2'd2, 1'b0, 4'h8, 1'b0, 1'b0, 1'b0, 4'h8};
      vecs[1] = '{1'b0, 4'h0, 4'h0, 4'h6, 2'd1, 2'd1, 2'd0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0};
      vecs[2] = '{1'b0, 4'h0, 4'h0, 4'h3, 2'd0, 2'd0, 2'd0, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 4'h1};
      vecs[3] = '{1'b1, 4'hF, 4'h1, 4'h2, 2'd0, 2'd1, 2'd3, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0};
      vecs[4] = '{1'b0, 4'h0, 4'h0, 4'h3, 2'd3, 2'd3, 2'd3, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 4'h1};
      vecs[5] = '{1'b0, 4'h0, 4'h0, 4'hA, 2'd0, 2'd1, 2'd2, 1'b0, 4'h1, 1'b1, 1'b0, 1'b1, 4'h8};
      vecs[6] = '{1'b0, 4'h0, 4'h0, 4'h1, 2'd0, 2'd3, 2'd1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 4'hF};
      vecs[7] = '{1'b0, 4'h0, 4'h0, 4'h4, 2'd2, 2'd2, 2'd2, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 4'h7};

      rst_i        = 1'b1;
      cmd_valid_i  = 1'b0;
      cmd_op_i     = '0;
      cmd_ra_i     = '0;
      cmd_rb_i     = '0;
      cmd_rd_i     = '0;
      cmd_flagin_i = 1'b0;
      ld_en_i      = 1'b0;
      ld_addr_i    = '0;
      ld_data_i    = '0;
      rd_addr_i    = '0;
      model_reset();

      repeat (2) @(negedge clk);
      rst_i = 1'b0;
      #1;
      check("reset_ready", cmd_ready_o, 1'b1);
      check("reset_done", done_o, 1'b0);
      check("reset_err", err_o, 1'b0);
      check("reset_result", result_o, '0);
      check("reset_carry", carry_o, 1'b0);
      check("reset_zero", zero_o, 1'b0);
      check("reset_alu_cont", alu_cont_o, 4'h0);
      check_regs("reset");

      // Directed vector table
      for (int i = 0; i < 8; i++) begin
         if (vecs[i].do_ld) begin
            do_load(2'd0, vecs[i].l0);
            do_load(2'd1, vecs[i].l1);
         end
         run_cmd(vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].rd, vecs[i].fin, 1'b0, 1'b1, e);
         check($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
         check($sformatf("vec%0d_result", i), result_o, vecs[i].exp_res);
         check($sformatf("vec%0d_carry", i), carry_o, vecs[i].exp_c);
         check($sformatf("vec%0d_zero", i), zero_o, vecs[i].exp_z);
         rd_addr_i = vecs[i].rd;
         #1 check($sformatf("vec%0d_rd_value", i), rd_data_o, vecs[i].exp_rdv);
      end

      // Load and command together: load wins, command waits one cycle
      @(negedge clk);
      ld_en_i      = 1'b1;
      ld_addr_i    = 2'd2;
      ld_data_i    = 4'h6;
      cmd_valid_i  = 1'b1;
      cmd_op_i     = 4'h1;
      cmd_ra_i     = 2'd2;
      cmd_rb_i     = 2'd2;
      cmd_rd_i     = 2'd0;
      cmd_flagin_i = 1'b0;
      #1 check("ld_cmd_ready_low", cmd_ready_o, 1'b0);
      @(negedge clk);
      ld_en_i   = 1'b0;
      m_regs[2] = 4'h6;
      rd_addr_i = 2'd2;
      #1;
      check("ld_cmd_not_accepted", alu_cont_o, 4'h0);
      check("ld_cmd_ready_after", cmd_ready_o, 1'b1);
      check("ld_cmd_loaded", rd_data_o, 4'h6);
      $display("load R2 = 6 with command pending");
      run_cmd(4'h1, 2'd2, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, e);

      // Load strobe during EXEC must be ignored
      run_cmd(4'h7, 2'd1, 2'd2, 2'd3, 1'b0, 1'b1, 1'b1, e);

      // Carry chaining: F + 1 sets carry, then R3 + R3 with flagin 0
      do_load(2'd0, 4'hF);
      do_load(2'd1, 4'h1);
      run_cmd(4'h2, 2'd0, 2'd1, 2'd3, 1'b0, 1'b0, 1'b1, e);
      run_cmd(4'h2, 2'd3, 2'd3, 2'd1, 1'b0, 1'b0, 1'b1, e);
      rd_addr_i = 2'd1;
`ifdef CARRY_CHAIN_EN
      #1 check("chain_add", rd_data_o, 4'h1);
`else
      #1 check("chain_add", rd_data_o, 4'h0);
`endif

      // Reset asserted during EXEC
      do_load(2'd2, 4'h9);
      @(negedge clk);
      cmd_op_i    = 4'h2;
      cmd_ra_i    = 2'd2;
      cmd_rb_i    = 2'd2;
      cmd_rd_i    = 2'd0;
      cmd_valid_i = 1'b1;
      @(negedge clk);
      cmd_valid_i = 1'b0;
      #1 check("rst_exec_in_exec", alu_cont_o, 4'h2);
      rst_i = 1'b1;
      model_reset();
      #1;
      check("rst_exec_done", done_o, 1'b0);
      check("rst_exec_result", result_o, '0);
      check("rst_exec_carry", carry_o, 1'b0);
      check("rst_exec_zero", zero_o, 1'b0);
      check("rst_exec_alu_cont", alu_cont_o, 4'h0);
      check_regs("rst_exec");
      @(negedge clk);
      rst_i = 1'b0;
      #1 check("rst_release_done", done_o, 1'b0);
      check("rst_release_ready", cmd_ready_o, 1'b1);
      @(negedge clk);
      #1 check("rst_release_done2", done_o, 1'b0);
      check("rst_release_ready2", cmd_ready_o, 1'b1);
      $display("reset during EXEC");

      // Randomized commands against the model
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            do_load(AW'($urandom), N'($urandom));
         end
         if ($urandom_range(0, 5) == 0) rop = 4'($urandom_range(10, 15));
         else rop = 4'($urandom_range(0, 9));
         run_cmd(rop, AW'($urandom), AW'($urandom), AW'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), 1'b1, e);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
